// File: rtl/mmu_seq_pkg.sv
// Shared state encoding, default geometry and counter sizing for the
// matrix-multiply tile sequencer.
package mmu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_WR = 3'd2,
    S_WLOAD   = 3'd3,
    S_RD      = 3'd4,
    S_COMPUTE = 3'd5,
    S_DONE    = 3'd6
  } seq_state_t;

  localparam int SYS_ROW_DEF      = 4;
  localparam int SYS_COL_DEF      = 4;
  localparam int DATA_WIDTH_DEF   = 16;
  localparam int ACCUM_SIZE_DEF   = 1024;
  localparam int WAIT_TIMEOUT_DEF = 256;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Watchdog: counts enabled cycles since the last clear and flags the
// LIMIT-th one, so the owner can abort a stalled wait.
module seq_timeout_cnt
  import mmu_seq_pkg::*;
#(
  parameter int LIMIT = WAIT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = cnt_w(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wait_cnt <= '0;
    end else if (en && (wait_cnt != LAST)) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  // A clear in the same cycle means progress was made, so no abort.
  assign expired = en && !clr && (wait_cnt == LAST);

endmodule

// File: rtl/mmu_tile_seq.sv
// Sequencer for one systolic matrix-multiply tile: loads input/weight rows,
// shifts weights into the array, launches the input read and counts results.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; bad row counts pulse err
// S_LOAD    | accepting row beats; first SYS_ROW beats also feed weight FIFO
// S_WAIT_WR | waiting for input memory to report write completion
// S_WLOAD   | shifting SYS_ROW weight rows from the FIFO into the array
// S_RD      | one-cycle input read launch
// S_COMPUTE | counting result beats at the last array column
// S_DONE    | one-cycle done pulse
module mmu_tile_seq
  import mmu_seq_pkg::*;
#(
  parameter int SYS_ROW      = SYS_ROW_DEF,
  parameter int SYS_COL      = SYS_COL_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ACCUM_SIZE   = ACCUM_SIZE_DEF,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num_row,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic                  wr_active,
  output logic                  fifo_en,
  output logic [SYS_COL-1:0]    w_wen,
  output logic                  rd_active,
  input  logic                  mem_wr_done,
  input  logic [SYS_COL-1:0]    arr_en_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BW = cnt_w(ACCUM_SIZE);
  localparam int LW = cnt_w(SYS_ROW);
  localparam logic [BW-1:0] SYS_ROW_B = BW'(SYS_ROW);
  localparam logic [LW-1:0] WL_LAST   = LW'(SYS_ROW - 1);

  seq_state_t    state, nxt;
  logic [BW-1:0] nrow_q, beat_cnt, res_cnt;
  logic [LW-1:0] wl_cnt;
  logic          fifo_wl, err_set, start_ok, hs, res_beat;
  logic          wd_clr, wd_en, wd_expired;
  logic          arr_unused;

  assign hs       = src_ready && src_valid;
  assign res_beat = (state == S_COMPUTE) && arr_en_out[SYS_COL-1];
  assign start_ok = (num_row != '0) && (num_row <= DATA_WIDTH'(ACCUM_SIZE));
  assign fifo_en  = fifo_wl || (hs && (beat_cnt < SYS_ROW_B));
  assign wd_en    = (state == S_WAIT_WR) || (state == S_COMPUTE);
  assign wd_clr   = !wd_en || res_beat;
  assign arr_unused = ^arr_en_out;

  seq_timeout_cnt #(.LIMIT(WAIT_TIMEOUT)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    case (state)
      S_IDLE:
        if (start) begin
          if (start_ok) nxt = S_LOAD;
          else          err_set = 1'b1;
        end
      S_LOAD:
        if (hs && (beat_cnt == nrow_q - BW'(1))) nxt = S_WAIT_WR;
      S_WAIT_WR:
        if (mem_wr_done) begin
          nxt = S_WLOAD;
        end else if (wd_expired) begin
          nxt     = S_IDLE;
          err_set = 1'b1;
        end
      S_WLOAD:
        if (wl_cnt == WL_LAST) nxt = S_RD;
      S_RD:
        nxt = S_COMPUTE;
      S_COMPUTE:
        if (res_beat && (res_cnt + BW'(1) == nrow_q)) begin
          nxt = S_DONE;
        end else if (wd_expired) begin
          nxt     = S_IDLE;
          err_set = 1'b1;
        end
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      nrow_q    <= '0;
      beat_cnt  <= '0;
      res_cnt   <= '0;
      wl_cnt    <= '0;
      src_ready <= 1'b0;
      wr_active <= 1'b0;
      fifo_wl   <= 1'b0;
      w_wen     <= '0;
      rd_active <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nxt;
      src_ready <= (nxt == S_LOAD);
      wr_active <= (nxt == S_LOAD) || (nxt == S_WAIT_WR);
      fifo_wl   <= (nxt == S_WLOAD);
      w_wen     <= (nxt == S_WLOAD) ? {SYS_COL{1'b1}} : '0;
      rd_active <= (nxt == S_RD);
      busy      <= (nxt != S_IDLE);
      done      <= (nxt == S_DONE);
      err       <= err_set;

      if ((state == S_IDLE) && (nxt == S_LOAD)) begin
        nrow_q   <= BW'(num_row);
        beat_cnt <= '0;
        res_cnt  <= '0;
        wl_cnt   <= '0;
      end else begin
        if (hs)                 beat_cnt <= beat_cnt + BW'(1);
        if (state == S_WLOAD)   wl_cnt   <= wl_cnt + LW'(1);
        if (res_beat)           res_cnt  <= res_cnt + BW'(1);
      end
    end
  end

endmodule
